// File: rtl/pic_bank_ctrl.sv
// Ping-pong frame-buffer write controller: fills the back bank, swaps banks on vsync.
// Optional saturating drop counter enabled by defining PIC_BANK_DROP_CNT_EN.
module pic_bank_ctrl #(
    parameter int unsigned PIC_SIZE = 31684,
    parameter int unsigned ADDR_W   = 15
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              rx_valid_flag,
    input  logic              vsync_pulse,
    input  logic              soft_clr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_bank,
    output logic              rd_bank,
    output logic              frame_rdy,
    output logic              frame_done,
    output logic              pend,
    output logic              drop_flag
`ifdef PIC_BANK_DROP_CNT_EN
   ,output logic [15:0]       drop_cnt
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIC_SIZE - 1);

    typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic              frame_rdy_q, frame_rdy_d;
    logic              frame_done_q, frame_done_d;
    logic              pend_q, pend_d;
    logic              drop_flag_q, drop_flag_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    logic accept;
    logic last_pix;

    // Pixels are only written while filling and not being aborted.
    assign accept   = rx_valid_flag & (state_q == FILL) & ~soft_clr;
    assign last_pix = accept & (wr_addr_q == LAST_ADDR);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (soft_clr) begin
            state_d = FILL;
        end else begin
            case (state_q)
                FILL:    if (last_pix)    state_d = FULL;
                FULL:    if (vsync_pulse) state_d = FILL;
                default: state_d = FILL;
            endcase
        end
    end

    always_comb begin
        wr_addr_d    = wr_addr_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        frame_rdy_d  = frame_rdy_q;
        frame_done_d = 1'b0;
        pend_d       = pend_q;
        drop_flag_d  = drop_flag_q;
        drop_cnt_d   = drop_cnt_q;
        if (soft_clr) begin
            wr_addr_d   = '0;
            pend_d      = 1'b0;
            drop_flag_d = 1'b0;
            drop_cnt_d  = '0;
        end else if (state_q == FILL) begin
            if (last_pix) begin
                wr_addr_d    = '0;
                pend_d       = 1'b1;
                frame_done_d = 1'b1;
            end else if (accept) begin
                wr_addr_d = wr_addr_q + ADDR_W'(1);
            end
        end else begin
            if (rx_valid_flag) begin
                drop_flag_d = 1'b1;
                if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
            end
            // Swap only here so the display never sees a partial frame.
            if (vsync_pulse) begin
                rd_bank_d   = wr_bank_q;
                wr_bank_d   = ~wr_bank_q;
                frame_rdy_d = 1'b1;
                pend_d      = 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_addr_q    <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b1;
            frame_rdy_q  <= 1'b0;
            frame_done_q <= 1'b0;
            pend_q       <= 1'b0;
            drop_flag_q  <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            wr_addr_q    <= wr_addr_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            frame_rdy_q  <= frame_rdy_d;
            frame_done_q <= frame_done_d;
            pend_q       <= pend_d;
            drop_flag_q  <= drop_flag_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign wr_en      = accept;
    assign wr_addr    = wr_addr_q;
    assign wr_bank    = wr_bank_q;
    assign rd_bank    = rd_bank_q;
    assign frame_rdy  = frame_rdy_q;
    assign frame_done = frame_done_q;
    assign pend       = pend_q;
    assign drop_flag  = drop_flag_q;
`ifdef PIC_BANK_DROP_CNT_EN
    assign drop_cnt   = drop_cnt_q;
`else
    logic unused_drop_cnt;
    assign unused_drop_cnt = ^drop_cnt_q;
`endif

endmodule

// File: doc/pic_bank_ctrl.md
Name: pic_bank_ctrl

Overview:
- Ping-pong frame-buffer controller between the edge-detection pixel stream and the VGA picture RAM.
- Writes incoming pixels into the back bank and tracks when a full frame has landed.
- Swaps front/back banks only on a vertical-sync pulse, so the display never shows a partially written frame.
- Drives the write side of the two-bank RAM and the bank-select bit used by the display read path.

Parameters:
- PIC_SIZE, 31684, pixels per frame (178×178 Sobel output).
- ADDR_W, 15, width of the per-bank pixel address; PIC_SIZE must be ≤ 2^ADDR_W.

Ports:
- sys_clk  in  1  system clock (50 MHz); all logic in this domain.
- sys_rst_n  in  1  asynchronous active-low reset.
- rx_valid_flag  in  1  pixel strobe from upstream; one pixel per high cycle.
- vsync_pulse  in  1  one-cycle pulse at start of vertical blanking, already synchronised to sys_clk.
- soft_clr  in  1  synchronous abort of the current fill.
- wr_en  out  1  RAM write enable.
- wr_addr  out  ADDR_W  RAM write address within the bank.
- wr_bank  out  1  bank being written (RAM address MSB on write side).
- rd_bank  out  1  bank being displayed (RAM address MSB on read side).
- frame_rdy  out  1  front bank holds a complete frame.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted.
- pend  out  1  back bank full, waiting for swap.
- drop_flag  out  1  sticky: a pixel arrived while writing was blocked.

Behaviour:
- Reset values: state FILL, wr_addr 0, wr_bank 0, rd_bank 1, frame_rdy 0, frame_done 0, pend 0, drop_flag 0.
- wr_en is combinational: rx_valid_flag & (state==FILL) & ~soft_clr. Zero latency; upstream data is presented in the same cycle.
- wr_addr, wr_bank, rd_bank, frame_rdy, pend, drop_flag and frame_done are registered.
- State FILL:
  - Each accepted pixel increments wr_addr.
  - Accepted pixel at wr_addr==PIC_SIZE-1: next cycle wr_addr=0, state=FULL, pend=1, frame_done=1 for one cycle.
  - vsync_pulse has no effect.
- State FULL:
  - wr_en=0.
  - rx_valid_flag=1 sets drop_flag (sticky); wr_addr holds at 0.
  - On vsync_pulse, next cycle: rd_bank←wr_bank, wr_bank←~wr_bank, frame_rdy←1, pend←0, state=FILL.
- Last pixel and vsync_pulse in the same cycle: go to FULL; the swap waits for the next vsync_pulse.
- rx_valid_flag in the swap cycle (FULL with vsync_pulse): pixel dropped and drop_flag set. The first write to the new back bank happens the cycle after.
- Invariant: rd_bank != wr_bank at all times.
- soft_clr (highest priority):
  - wr_addr←0, state←FILL, pend←0, drop_flag←0, frame_done←0.
  - wr_bank, rd_bank and frame_rdy are unchanged.
  - A concurrent vsync_pulse is ignored; the pixel is not written.
- Reset mid-frame returns all outputs to reset values asynchronously.
- wr_addr wraps only via the terminal-count rule; it never exceeds PIC_SIZE-1.

Optional Feature:
- Macro PIC_BANK_DROP_CNT_EN.
- When defined:
  - Adds output drop_cnt [15:0], a saturating count (holds at 16'hFFFF) of pixels dropped in FULL.
  - Reset value 0; cleared by soft_clr.
  - Increments in the same cycle drop_flag would be set.
- When undefined: no port and no counter; drop_flag only.

Test Plan:
- Reset check: assert sys_rst_n=0 → wr_bank=0, rd_bank=1, wr_addr=0, frame_rdy=0, pend=0, drop_flag=0.
- Full frame: with PIC_SIZE=4, drive 4 strobes → wr_addr 0,1,2,3, wr_en=1 each cycle; frame_done high one cycle; pend=1; wr_addr=0.
- Swap: from the full-frame end, pulse vsync_pulse → next cycle rd_bank=0, wr_bank=1, frame_rdy=1, pend=0; the next strobe writes addr 0 with wr_en=1.
- Overflow: in FULL, drive 3 strobes → wr_en=0 throughout, drop_flag=1; with PIC_BANK_DROP_CNT_EN, drop_cnt=3. A further vsync_pulse still swaps.
- Simultaneous events: last pixel and vsync_pulse in the same cycle → pend=1, rd_bank unchanged (1); the next vsync_pulse swaps. A vsync_pulse during FILL at wr_addr=2 → no bank change.
- soft_clr mid-fill: at wr_addr=2 with wr_bank=1, assert soft_clr with rx_valid_flag=1 → wr_en=0; next cycle wr_addr=0, banks unchanged, drop_flag=0.
